tmul_issue_ctrl: RTL and testbench

//  Issue/drain sequencer for the 8x8 tile multiplier (TMUL_32_8mul8). Accepts a job command (N operand beats),

---
 rtl/tmul_issue_ctrl_if.sv | 32 +++
 rtl/tmul_issue_ctrl.sv | 176 +++++++++++++++++
 tb/tb_tmul_issue_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/tmul_issue_ctrl_if.sv
// tmul_issue_ctrl_if: groups the command, operand-issue and result handshakes of tmul_issue_ctrl.
//   master : the surrounding system (fetch unit, TMUL c output, result writer)
//   slave  : tmul_issue_ctrl
// Signals: cmd_valid/cmd_ready/cmd_beats, op_valid/op_ready, c_flat,
//          res_valid/res_ready/res_data/res_last, busy, done.
interface tmul_issue_ctrl_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned C_W   = 512
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_beats;
  logic             op_valid;
  logic             op_ready;
  logic [C_W-1:0]   c_flat;
  logic             res_valid;
  logic             res_ready;
  logic [C_W-1:0]   res_data;
  logic             res_last;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_beats, op_valid, c_flat, res_ready,
    input  cmd_ready, op_ready, res_valid, res_data, res_last, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_beats, op_valid, c_flat, res_ready,
    output cmd_ready, op_ready, res_valid, res_data, res_last, busy, done
  );
endinterface

// File: rtl/tmul_issue_ctrl.sv
// tmul_issue_ctrl: issue/drain sequencer for the 8x8 tile multiplier.
// Paces operand beats into the fixed-latency TMUL, tracks them with a tag pipe and
// buffers C rows in a credit-protected result FIFO.
// Ports:
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-low reset
//   bus (slave)    command / operand / result handshakes, busy, done
//   o_perf_busy    cycles with busy=1 (only with TMUL_PERF_CNT_EN)
//   o_perf_stall   cycles RUN && op_valid && !op_ready (only with TMUL_PERF_CNT_EN)
// Optional feature macro: TMUL_PERF_CNT_EN (saturating performance counters).
module tmul_issue_ctrl #(
  parameter int unsigned LAT        = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned C_W        = 512
) (
  input  logic              i_clk,
  input  logic              i_rst,
  tmul_issue_ctrl_if.slave  bus
`ifdef TMUL_PERF_CNT_EN
  ,
  output logic [31:0]       o_perf_busy,
  output logic [31:0]       o_perf_stall
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CRD_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_beats, r_issued;
  logic [CRD_W-1:0]      r_credits, r_count;
  logic [LAT-1:0]        r_tag_v, r_tag_l;
  logic [C_W-1:0]        r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_last;
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic                  r_done;

  logic w_cmd_acc, w_op_ready, w_issue, w_last_issue, w_push, w_pop, w_done_nxt;

  assign w_issue      = w_op_ready && bus.op_valid;
  assign w_last_issue = w_issue && (r_issued == r_beats - CNT_W'(1));
  assign w_push       = r_tag_v[LAT-1];
  assign w_pop        = (r_count != '0) && bus.res_ready;

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, issue gating and completion pulse
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_acc   = 1'b0;
    w_op_ready  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_acc = bus.cmd_valid;
        if (w_cmd_acc) begin
          if (bus.cmd_beats == '0) w_done_nxt  = 1'b1;
          else                     w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_op_ready = (r_issued != r_beats) && (r_credits != '0);
        if (w_op_ready && bus.op_valid && (r_issued == r_beats - CNT_W'(1)))
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_pop && r_mem_last[r_rd_ptr]) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Job counters, credits (taken at issue, returned at pop) and done pulse
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_beats   <= '0;
      r_issued  <= '0;
      r_credits <= CRD_W'(FIFO_DEPTH);
      r_done    <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_cmd_acc) begin
        r_beats  <= bus.cmd_beats;
        r_issued <= '0;
      end else if (w_issue) begin
        r_issued <= r_issued + CNT_W'(1);
      end
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - CRD_W'(1);
        2'b01:   r_credits <= r_credits + CRD_W'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Tag pipe mirrors the TMUL pipeline: a tag leaving stage LAT-1 marks c_flat valid
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tag_v <= '0;
      r_tag_l <= '0;
    end else begin
      r_tag_v[0] <= w_issue;
      r_tag_l[0] <= w_last_issue;
      for (int i = 1; i < int'(LAT); i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_l[i] <= r_tag_l[i-1];
      end
    end
  end

  // Result FIFO; credits guarantee a push always finds space
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
      r_mem_last <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr]      <= bus.c_flat;
        r_mem_last[r_wr_ptr] <= r_tag_l[LAT-1];
        r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CRD_W'(1);
        2'b01:   r_count <= r_count - CRD_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef TMUL_PERF_CNT_EN
  logic [31:0] r_perf_busy, r_perf_stall;

  // Saturating activity counters, restarted by each accepted command
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_perf_busy  <= '0;
      r_perf_stall <= '0;
    end else if (w_cmd_acc) begin
      r_perf_busy  <= '0;
      r_perf_stall <= '0;
    end else begin
      if ((r_state != S_IDLE) && (r_perf_busy != '1))
        r_perf_busy <= r_perf_busy + 32'd1;
      if ((r_state == S_RUN) && bus.op_valid && !w_op_ready && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign o_perf_busy  = r_perf_busy;
  assign o_perf_stall = r_perf_stall;
`endif

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.op_ready  = w_op_ready;
  assign bus.res_valid = (r_count != '0);
  assign bus.res_data  = r_mem[r_rd_ptr];
  assign bus.res_last  = (r_count != '0) && r_mem_last[r_rd_ptr];
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;

endmodule

// File: tb/tb_tmul_issue_ctrl.sv
// tb_tmul_issue_ctrl: randomized bench for tmul_issue_ctrl against a transaction-level model
// (job bookkeeping, a queue of expected results stamped with their issue cycle, and a
// cycle-indexed model of the TMUL c output).
module tb_tmul_issue_ctrl;
  localparam int unsigned LAT   = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned C_W   = 512;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tmul_issue_ctrl_if #(.CNT_W(CNT_W), .C_W(C_W)) bus ();

`ifdef TMUL_PERF_CNT_EN
  logic [31:0] perf_busy, perf_stall;
`endif

  tmul_issue_ctrl #(.LAT(LAT), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W), .C_W(C_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef TMUL_PERF_CNT_EN
    ,
    .o_perf_busy  (perf_busy),
    .o_perf_stall (perf_stall)
`endif
  );

  typedef struct {
    logic [C_W-1:0] data;
    logic           last;
    int             cyc;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;

  exp_t           q[$];
  logic [C_W-1:0] sched_d [64];
  bit             sched_v [64];
  int             cyc = 0;
  bit             m_active = 0, m_done_pend = 0;
  int             m_n = 0, m_issued = 0, m_popped = 0;
  int             m_pb = 0, m_ps = 0;
  int             dut_iss = 0, dut_pops = 0;

  task automatic check_eq(input string tag, input logic [C_W-1:0] got, input logic [C_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [C_W-1:0] rand_row();
    logic [C_W-1:0] v;
    for (int i = 0; i < int'(C_W / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input bit cv, input int nb, input int opv_pct, input int rr_pct);
    bit e_busy, e_ready, e_opr, e_rv, acc, iss, pop, lst;
    logic [C_W-1:0] d;
    int slot;
    e_busy  = m_active;
    e_ready = !m_active;
    e_opr   = m_active && (m_issued < m_n) && ((m_issued - m_popped) < int'(DEPTH));
    e_rv    = (q.size() > 0) && (q[0].cyc + int'(LAT) + 1 <= cyc);
    check_eq("cmd_ready", C_W'(bus.cmd_ready), C_W'(e_ready));
    check_eq("busy",      C_W'(bus.busy),      C_W'(e_busy));
    check_eq("done",      C_W'(bus.done),      C_W'(m_done_pend));
    check_eq("op_ready",  C_W'(bus.op_ready),  C_W'(e_opr));
    check_eq("res_valid", C_W'(bus.res_valid), C_W'(e_rv));
    if (e_rv) begin
      check_eq("res_data", bus.res_data, q[0].data);
      check_eq("res_last", C_W'(bus.res_last), C_W'(q[0].last));
    end
`ifdef TMUL_PERF_CNT_EN
    check_eq("perf_busy",  C_W'(perf_busy),  C_W'(m_pb));
    check_eq("perf_stall", C_W'(perf_stall), C_W'(m_ps));
`endif
    bus.cmd_valid = cv;
    bus.cmd_beats = CNT_W'(nb);
    bus.op_valid  = ($urandom_range(99) < opv_pct);
    bus.res_ready = ($urandom_range(99) < rr_pct);
    slot = cyc % 64;
    bus.c_flat = sched_v[slot] ? sched_d[slot] : rand_row();
    sched_v[slot] = 0;
    if (bus.op_ready && bus.op_valid) dut_iss++;
    if (bus.res_valid && bus.res_ready) dut_pops++;

    acc = e_ready && cv;
    iss = e_opr && bus.op_valid;
    pop = e_rv && bus.res_ready;
    if (acc) begin
      m_pb = 0;
      m_ps = 0;
    end else begin
      if (e_busy) m_pb++;
      if (m_active && (m_issued < m_n) && bus.op_valid && !e_opr) m_ps++;
    end
    m_done_pend = 0;
    if (acc) begin
      if (nb == 0) m_done_pend = 1;
      else begin
        m_active = 1; m_n = nb; m_issued = 0; m_popped = 0;
      end
    end
    if (iss) begin
      d = rand_row();
      sched_d[(cyc + int'(LAT)) % 64] = d;
      sched_v[(cyc + int'(LAT)) % 64] = 1;
      q.push_back('{data: d, last: (m_issued == m_n - 1), cyc: cyc});
      m_issued++;
    end
    if (pop) begin
      lst = q[0].last;
      void'(q.pop_front());
      m_popped++;
      if (lst) begin
        m_active    = 0;
        m_done_pend = 1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic finish_job(input int opv_pct, input int rr_pct, input int budget);
    int n = 0;
    while (m_active && n < budget) begin
      step(1'b0, 0, opv_pct, rr_pct);
      n++;
    end
    if (m_active) check_eq("job_timeout", C_W'(1), C_W'(0));
    step(1'b0, 0, opv_pct, rr_pct);
    step(1'b0, 0, opv_pct, rr_pct);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check_eq("rst_op_ready",  C_W'(bus.op_ready),  C_W'(0));
    check_eq("rst_res_valid", C_W'(bus.res_valid), C_W'(0));
    check_eq("rst_res_last",  C_W'(bus.res_last),  C_W'(0));
    check_eq("rst_res_data",  bus.res_data,        C_W'(0));
    check_eq("rst_busy",      C_W'(bus.busy),      C_W'(0));
    check_eq("rst_done",      C_W'(bus.done),      C_W'(0));
    bus.cmd_valid = 1'b0;
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b0;
    q.delete();
    for (int i = 0; i < 64; i++) sched_v[i] = 0;
    m_active = 0; m_done_pend = 0; m_issued = 0; m_popped = 0; m_n = 0;
    m_pb = 0; m_ps = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_cmd_ready", C_W'(bus.cmd_ready), C_W'(1));
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_beats = '0;
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b0;
    bus.c_flat    = '0;
    for (int i = 0; i < 64; i++) sched_v[i] = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // Short job, full throughput
    dut_iss = 0; dut_pops = 0;
    step(1'b1, 4, 100, 100);
    finish_job(100, 100, 100);
    check_eq("t2_issued", C_W'(dut_iss), C_W'(4));
    check_eq("t2_popped", C_W'(dut_pops), C_W'(4));

    // Writer stalled: only FIFO_DEPTH beats may issue
    dut_iss = 0; dut_pops = 0;
    step(1'b1, 20, 100, 0);
    repeat (30) step(1'b0, 0, 100, 0);
    check_eq("t3_issued_stalled", C_W'(dut_iss), C_W'(DEPTH));
    finish_job(100, 100, 200);
    check_eq("t3_issued", C_W'(dut_iss), C_W'(20));
    check_eq("t3_popped", C_W'(dut_pops), C_W'(20));

    // Zero-beat job
    dut_iss = 0;
    step(1'b1, 0, 100, 100);
    step(1'b0, 0, 100, 100);
    step(1'b0, 0, 100, 100);
    check_eq("t4_no_issue", C_W'(dut_iss), C_W'(0));

    // Long random job, reset in the middle, then a fresh short job
    step(1'b1, 200, 50, 50);
    for (int n = 0; n < 3000 && m_issued < 100; n++)
      step(m_active ? 1'($urandom_range(1)) : 1'b0, int'($urandom_range(65535)), 50, 50);
    check_eq("t5_reached_beat100", C_W'(m_issued >= 100), C_W'(1));
    do_reset();
    dut_pops = 0;
    step(1'b1, 3, 100, 100);
    finish_job(100, 100, 100);
    check_eq("t5_popped", C_W'(dut_pops), C_W'(3));

    // Random mix of short jobs with random handshakes
    for (int j = 0; j < 6; j++) begin
      step(1'b1, int'($urandom_range(1, 24)), int'($urandom_range(30, 100)), int'($urandom_range(30, 100)));
      finish_job(60, 60, 1000);
    end

    // Perf counters: writer held off for 20 cycles
    step(1'b1, 10, 100, 0);
    repeat (20) step(1'b0, 0, 100, 0);
    finish_job(100, 100, 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
